decode_queue: RTL

Elastic buffer between the decode output mux and the issue stage. Captures one decoded instruction per cycle from the decode mux, holds up to `depth` entries in order, and presents the oldest entry to issue through a valid/ready handshake. Because decode has no internal stall, the queue asserts an early stall so that instructions already in flight upstream still fit. Flush discards all buffered work on redirect.

---
 rtl/decode_queue_pkg.sv | 44 ++++
 rtl/decode_queue_storage.sv | 23 ++
 rtl/decode_queue.sv | 133 +++++++++++++
 3 files changed

// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: widths, functional-unit IDs and the
// packed decoded-instruction entry passed from decode to issue.
package decode_queue_pkg;

  localparam int OPCODE_W = 12;
  localparam int ADDR_W   = 64;
  localparam int FU_W     = 3;
  localparam int MAJ_W    = 64;
  localparam int MIN_W    = 7;
  localparam int PID_W    = 20;
  localparam int TID_W    = 16;
  localparam int BODY_W   = 84;
  localparam int RAP_W    = 2;

  typedef enum logic [FU_W-1:0] {
    FU_FX     = 3'd0,
    FU_FP     = 3'd1,
    FU_VX     = 3'd2,
    FU_CR     = 3'd3,
    FU_LS     = 3'd4,
    FU_BRANCH = 3'd6
  } fu_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   address;
    logic [FU_W-1:0]     fu;
    logic [MAJ_W-1:0]    maj_id;
    logic [MIN_W-1:0]    min_id;
    logic                is64;
    logic [PID_W-1:0]    pid;
    logic [TID_W-1:0]    tid;
    logic [BODY_W-1:0]   body;
    logic [RAP_W-1:0]    op1rw;
    logic [RAP_W-1:0]    op2rw;
    logic [RAP_W-1:0]    op3rw;
    logic [RAP_W-1:0]    op4rw;
    logic                op1_is_reg;
    logic                op2_is_reg;
    logic                op3_is_reg;
    logic                op4_is_reg;
  } dec_entry_t;

endpackage

// File: rtl/decode_queue_storage.sv
// Entry register array: one write port, one asynchronous read port.
// Contents are intentionally left unreset.
module decode_queue_storage #(
  parameter int depth = 8,
  parameter int width = 32
) (
  input  logic                     clock_i,
  input  logic                     write_en,
  input  logic [$clog2(depth)-1:0] write_addr,
  input  logic [width-1:0]         write_data,
  input  logic [$clog2(depth)-1:0] read_addr,
  output logic [width-1:0]         read_data
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clock_i) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/decode_queue.sv
// Elastic buffer between decode mux and issue, with early stall
// so in-flight decode slots always find room.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int depth                   = 8,
  parameter int skid                    = 3,
  parameter int opcodeSize              = OPCODE_W,
  parameter int addressWidth            = ADDR_W,
  parameter int funcUnitCodeSize        = FU_W,
  parameter int instructionCounterWidth = MAJ_W,
  parameter int instMinIdWidth          = MIN_W,
  parameter int PidSize                 = PID_W,
  parameter int TidSize                 = TID_W,
  parameter int bodyWidth               = BODY_W,
  parameter int regAccessPatternSize    = RAP_W
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               enable_i,
  input  logic [opcodeSize-1:0]              opcode_i,
  input  logic [addressWidth-1:0]            address_i,
  input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
  input  logic [instructionCounterWidth-1:0] majID_i,
  input  logic [instMinIdWidth-1:0]          minID_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 pid_i,
  input  logic [TidSize-1:0]                 tid_i,
  input  logic [bodyWidth-1:0]               body_i,
  input  logic [regAccessPatternSize-1:0]    op1rw_i,
  input  logic [regAccessPatternSize-1:0]    op2rw_i,
  input  logic [regAccessPatternSize-1:0]    op3rw_i,
  input  logic [regAccessPatternSize-1:0]    op4rw_i,
  input  logic                               op1IsReg_i,
  input  logic                               op2IsReg_i,
  input  logic                               op3IsReg_i,
  input  logic                               op4IsReg_i,
  output logic                               stall_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [addressWidth-1:0]            address_o,
  output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
  output logic [instructionCounterWidth-1:0] majID_o,
  output logic [instMinIdWidth-1:0]          minID_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 pid_o,
  output logic [TidSize-1:0]                 tid_o,
  output logic [bodyWidth-1:0]               body_o,
  output logic [regAccessPatternSize-1:0]    op1rw_o,
  output logic [regAccessPatternSize-1:0]    op2rw_o,
  output logic [regAccessPatternSize-1:0]    op3rw_o,
  output logic [regAccessPatternSize-1:0]    op4rw_o,
  output logic                               op1IsReg_o,
  output logic                               op2IsReg_o,
  output logic                               op3IsReg_o,
  output logic                               op4IsReg_o,
  output logic [$clog2(depth):0]             count_o,
  output logic                               overflow_o
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam int EW = opcodeSize + addressWidth + funcUnitCodeSize
                    + instructionCounterWidth + instMinIdWidth + 1
                    + PidSize + TidSize + bodyWidth
                    + 4 * regAccessPatternSize + 4;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          deq;
  logic          enq;
  logic          drop;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  assign full    = (count == CW'(depth));
  assign valid_o = (count != '0);
  assign deq     = valid_o & ready_i;
  // A full queue still accepts when the head leaves in the same cycle.
  assign enq     = enable_i & (~full | deq);
  assign drop    = enable_i & full & ~deq;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      if (enq && !deq) count <= count + CW'(1);
      else if (deq && !enq) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign count_o    = count;
  assign overflow_o = overflow;
  assign stall_o    = (CW'(depth) - count) <= CW'(skid);

  assign wdata = {opcode_i, address_i, funcUnitType_i, majID_i,
                  minID_i, is64Bit_i, pid_i, tid_i, body_i,
                  op1rw_i, op2rw_i, op3rw_i, op4rw_i,
                  op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i};

  decode_queue_storage #(
    .depth (depth),
    .width (EW)
  ) u_storage (
    .clock_i    (clock_i),
    .write_en   (enq & ~flush_i),
    .write_addr (tail),
    .write_data (wdata),
    .read_addr  (head),
    .read_data  (rdata)
  );

  assign {opcode_o, address_o, funcUnitType_o, majID_o,
          minID_o, is64Bit_o, pid_o, tid_o, body_o,
          op1rw_o, op2rw_o, op3rw_o, op4rw_o,
          op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o} = rdata;

endmodule
